// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus DDR input deserializer.
package hyperbus_pkg;

  localparam int unsigned WordWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCapture
  } cap_state_e;

endpackage

// File: rtl/hyperbus_ddr_in_fifo.sv
// Output buffer for the DDR deserializer: power-of-two ring with a registered head word.
module hyperbus_ddr_in_fifo
  import hyperbus_pkg::*;
#(
  parameter int unsigned          Depth = 4,
  parameter logic [WordWidth-1:0] Init  = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WordWidth-1:0]       data_i,
  input  logic                       ready_i,
  output logic [WordWidth-1:0]       data_o,
  output logic                       valid_o,
  output logic [$clog2(Depth):0]     fill_o,
  output logic                       drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [WordWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q, rd_after;
  logic [CntW-1:0]      count_q, count_d, cnt_after_pop;
  logic [WordWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 full, pop, do_push;

  assign full    = (count_q == CntW'(Depth));
  assign pop     = valid_q & ready_i;
  assign do_push = push_i & (~full | pop);
  assign drop_o  = push_i & full & ~pop & ~clear_i;

  // The head register only sees words already stored before this edge, so a push
  // into an empty buffer shows up on valid_o one edge later (no bypass).
  always_comb begin
    rd_after      = rd_ptr_q + PtrW'(pop);
    cnt_after_pop = count_q - CntW'(pop);
    count_d       = count_q + CntW'(do_push) - CntW'(pop);
    valid_d       = (cnt_after_pop != '0);
    data_d        = valid_d ? mem_q[rd_after] : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= Init;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(do_push);
      rd_ptr_q <= rd_after;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign fill_o  = count_q;

endmodule

// File: rtl/hyperbus_ddr_in_deser.sv
// HyperBus DDR input deserializer: captures dq on both clock edges into 16-bit words.
// Define HYPERBUS_DDR_IN_OVF_CNT_EN to build the saturating dropped-word counter.
module hyperbus_ddr_in_deser
  import hyperbus_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter logic [15:0] Init      = 16'h0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       clear_i,
  input  logic [7:0]                 dq_i,
  output logic [15:0]                data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       overflow_o,
  output logic [$clog2(FifoDepth):0] fill_o,
  output logic [7:0]                 ovf_cnt_o
);

  logic [7:0] rise_q, fall_q;
  cap_state_e state_q;
  logic       push, drop, overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rise_q <= Init[15:8];
    else         rise_q <= dq_i;
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fall_q <= Init[7:0];
    else         fall_q <= dq_i;
  end

  // ARM lets the enabling cycle's half-word go by; pushes start one edge later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else if (clear_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (en_i) state_q <= StArm;
        StArm:     state_q <= StCapture;
        StCapture: if (!en_i) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign push = (state_q == StCapture);

  hyperbus_ddr_in_fifo #(
    .Depth (FifoDepth),
    .Init  (Init)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  ({rise_q, fall_q}),
    .ready_i (ready_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .fill_o  (fill_o),
    .drop_o  (drop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      overflow_q <= 1'b0;
    else if (clear_i) overflow_q <= 1'b0;
    else if (drop)    overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

`ifdef HYPERBUS_DDR_IN_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          ovf_cnt_q <= 8'h00;
    else if (clear_i)                     ovf_cnt_q <= 8'h00;
    else if (drop && ovf_cnt_q != 8'hFF)  ovf_cnt_q <= ovf_cnt_q + 8'h01;
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign ovf_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_hyperbus_ddr_in_deser.sv
// Directed bench for hyperbus_ddr_in_deser (FifoDepth=4, Init=16'h5A5A).
module tb_hyperbus_ddr_in_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clear, ready;
  logic [7:0] dq;
  logic [15:0] data;
  logic       valid, overflow;
  logic [2:0] fill;
  logic [7:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

`ifdef HYPERBUS_DDR_IN_OVF_CNT_EN
  localparam logic [7:0] CntOne = 8'h01;
  localparam logic [7:0] CntSat = 8'hFF;
`else
  localparam logic [7:0] CntOne = 8'h00;
  localparam logic [7:0] CntSat = 8'h00;
`endif

  hyperbus_ddr_in_deser #(
    .FifoDepth (4),
    .Init      (16'h5A5A)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .clear_i    (clear),
    .dq_i       (dq),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .overflow_o (overflow),
    .fill_o     (fill),
    .ovf_cnt_o  (ovf_cnt)
  );

  always #5 clk = ~clk;

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic e, input logic r, input logic c,
                      input logic [7:0] rb, input logic [7:0] fb);
    en = e; ready = r; clear = c; dq = rb;
    @(posedge clk); #1;
    dq = fb;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (data !== 16'h5A5A) begin errors++; $display("FAIL reset_data got %h want 5a5a", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if (ovf_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h want 00", ovf_cnt); end
  endtask

  task automatic test_basic();
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'hA1, 8'hB2);
    step(1, 0, 0, 8'hC3, 8'hD4);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL basic_fill1 got %0d want 1", fill); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", valid); end
    step(0, 0, 0, 8'h00, 8'h00);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", valid); end
    checks++; if (data !== 16'hA1B2) begin errors++; $display("FAIL basic_word0 got %h want a1b2", data); end
    checks++; if (fill !== 3'd2) begin errors++; $display("FAIL basic_fill2 got %0d want 2", fill); end
    step(0, 1, 0, 8'h00, 8'h00);
    checks++; if (data !== 16'hC3D4 || valid !== 1'b1) begin
      errors++; $display("FAIL basic_word1 got %h/%b want c3d4/1", data, valid); end
    step(0, 1, 0, 8'h00, 8'h00);
    checks++; if (valid !== 1'b0 || fill !== 3'd0) begin
      errors++; $display("FAIL basic_drain got valid %b fill %0d want 0/0", valid, fill); end
  endtask

  task automatic test_backpressure();
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h11, 8'h11);
    step(1, 0, 0, 8'h22, 8'h22);
    step(1, 0, 0, 8'h33, 8'h33);
    step(1, 0, 0, 8'h44, 8'h44);
    checks++; if (data !== 16'h1111) begin errors++; $display("FAIL bp_head3 got %h want 1111", data); end
    step(1, 0, 0, 8'h55, 8'h55);
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL bp_fill got %0d want 4", fill); end
    checks++; if (data !== 16'h1111 || overflow !== 1'b0) begin
      errors++; $display("FAIL bp_full got %h/%b want 1111/0", data, overflow); end
    step(0, 0, 0, 8'h00, 8'h00);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b want 1", overflow); end
    checks++; if (ovf_cnt !== CntOne) begin errors++; $display("FAIL bp_cnt got %h want %h", ovf_cnt, CntOne); end
    checks++; if (data !== 16'h1111 || fill !== 3'd4) begin
      errors++; $display("FAIL bp_after_drop got %h/%0d want 1111/4", data, fill); end
  endtask

  task automatic test_clear();
    step(0, 1, 0, 8'h00, 8'h00);
    checks++; if (fill !== 3'd3 || data !== 16'h2222) begin
      errors++; $display("FAIL clr_pre got %0d/%h want 3/2222", fill, data); end
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 1, 8'h00, 8'h00);
    checks++; if (fill !== 3'd0 || valid !== 1'b0) begin
      errors++; $display("FAIL clr_fifo got fill %0d valid %b want 0/0", fill, valid); end
    checks++; if (overflow !== 1'b0 || ovf_cnt !== 8'h00) begin
      errors++; $display("FAIL clr_ovf got %b/%h want 0/00", overflow, ovf_cnt); end
    step(1, 0, 0, 8'h00, 8'h00);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_idle1 got %0d want 0", fill); end
    step(1, 0, 0, 8'h00, 8'h00);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clr_idle2 got %0d want 0", fill); end
    step(0, 0, 0, 8'h00, 8'h00);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL clr_restart got %0d want 1", fill); end
    step(0, 0, 1, 8'h00, 8'h00);
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h3003; exp_w[1] = 16'h4004; exp_w[2] = 16'h5005;
    step(1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 0, 8'h10, 8'h01);
    step(1, 0, 0, 8'h20, 8'h02);
    step(1, 0, 0, 8'h30, 8'h03);
    step(1, 0, 0, 8'h40, 8'h04);
    step(1, 0, 0, 8'h50, 8'h05);
    checks++; if (fill !== 3'd4 || data !== 16'h1001) begin
      errors++; $display("FAIL fpp_full got %0d/%h want 4/1001", fill, data); end
    step(0, 1, 0, 8'h00, 8'h00);
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL fpp_fill got %0d want 4", fill); end
    checks++; if (data !== 16'h2002 || valid !== 1'b1) begin
      errors++; $display("FAIL fpp_head got %h/%b want 2002/1", data, valid); end
    checks++; if (overflow !== 1'b0 || ovf_cnt !== 8'h00) begin
      errors++; $display("FAIL fpp_noovf got %b/%h want 0/00", overflow, ovf_cnt); end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'h00, 8'h00);
      checks++; if (data !== exp_w[i] || fill !== 3'(3 - i)) begin
        errors++; $display("FAIL fpp_drain%0d got %h/%0d want %h/%0d", i, data, fill, exp_w[i], 3 - i);
      end
    end
    step(0, 1, 0, 8'h00, 8'h00);
    checks++; if (valid !== 1'b0 || fill !== 3'd0) begin
      errors++; $display("FAIL fpp_empty got %b/%0d want 0/0", valid, fill); end
  endtask

  task automatic test_saturation();
    repeat (310) step(1, 0, 0, 8'hEE, 8'h77);
    step(0, 0, 0, 8'h00, 8'h00);
    checks++; if (ovf_cnt !== CntSat) begin errors++; $display("FAIL sat_cnt got %h want %h", ovf_cnt, CntSat); end
    checks++; if (overflow !== 1'b1 || fill !== 3'd4 || data !== 16'hEE77) begin
      errors++; $display("FAIL sat_state got %b/%0d/%h want 1/4/ee77", overflow, fill, data); end
    step(0, 0, 1, 8'h00, 8'h00);
    checks++; if (ovf_cnt !== 8'h00 || overflow !== 1'b0) begin
      errors++; $display("FAIL sat_clear got %h/%b want 00/0", ovf_cnt, overflow); end
  endtask

  task automatic test_reset_mid_capture();
    step(1, 1, 0, 8'h00, 8'h00);
    step(1, 1, 0, 8'h61, 8'h62);
    step(1, 1, 0, 8'h63, 8'h64);
    step(1, 1, 0, 8'h65, 8'h66);
    checks++; if (valid !== 1'b1 || data !== 16'h6162) begin
      errors++; $display("FAIL rmc_pre got %b/%h want 1/6162", valid, data); end
    rst_n = 1'b0; #1;
    checks++; if (valid !== 1'b0 || fill !== 3'd0 || data !== 16'h5A5A) begin
      errors++; $display("FAIL rmc_async got %b/%0d/%h want 0/0/5a5a", valid, fill, data); end
    #1 rst_n = 1'b1;
    step(1, 0, 0, 8'h71, 8'h72);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rmc_edge1 got %0d want 0", fill); end
    step(1, 0, 0, 8'h73, 8'h74);
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rmc_edge2 got %0d want 0", fill); end
    step(1, 0, 0, 8'h75, 8'h76);
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL rmc_edge3 got %0d want 1", fill); end
    step(0, 0, 0, 8'h00, 8'h00);
    checks++; if (data !== 16'h7374 || valid !== 1'b1) begin
      errors++; $display("FAIL rmc_word got %h/%b want 7374/1", data, valid); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; ready = 1'b0; dq = 8'h00;
    #12;
    test_reset();
    #1 rst_n = 1'b1;
    test_basic();
    test_backpressure();
    test_clear();
    test_full_push_pop();
    test_saturation();
    test_reset_mid_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hyperbus_ddr_in_deser.md
HYPERBUS_DDR_IN_DESER -- requirements
Module: hyperbus_ddr_in_deser

Interface
REQ-001 SHALL have parameter FifoDepth, default 4, meaning output-buffer depth in 16-bit words; legal values are powers of two, minimum 2.
REQ-002 SHALL have parameter logic [15:0] Init, default 16'h0000, meaning the reset value of data_o and of all capture registers.
REQ-003 SHALL have port clk_i  input  1  capture clock; data is sampled on both edges.
REQ-004 SHALL have port rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port en_i  input  1  capture enable, sampled on the rising edge.
REQ-006 SHALL have port clear_i  input  1  synchronous flush of the buffer and state.
REQ-007 SHALL have port dq_i  input  8  DDR data bus.
REQ-008 SHALL have port data_o  output  16  head word of the buffer.
REQ-009 SHALL have port valid_o  output  1  data_o holds a valid word.
REQ-010 SHALL have port ready_i  input  1  consumer accepts data_o.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: a word was dropped.
REQ-012 SHALL have port fill_o  output  $clog2(FifoDepth)+1  current buffer occupancy.
REQ-013 SHALL have port ovf_cnt_o  output  8  saturating count of dropped words.

Function
REQ-014 SHALL sample dq_i on each rising edge of clk_i into rise_q, and on each falling edge into fall_q.
REQ-015 SHALL form a word as {rise_q, fall_q}: the rising-edge byte is bits [15:8] and the following falling-edge byte is bits [7:0].
REQ-016 SHALL use an FSM with states IDLE, ARM and CAPTURE.
- IDLE -> ARM when en_i=1.
- ARM -> CAPTURE on the next rising edge.
- CAPTURE -> IDLE when en_i=0.
- Any state -> IDLE when clear_i=1.
REQ-017 SHALL push the pair {rise_q, fall_q} at every rising edge while in CAPTURE; a pair's bytes, sampled at rising edge N and falling edge N+0.5, are pushed at rising edge N+1.
REQ-018 SHALL push nothing in IDLE or ARM, so the half-word sampled in the enabling cycle is discarded.
REQ-019 SHALL assert valid_o on the rising edge after a push into an empty buffer; minimum latency from the rising-edge byte to valid_o is 2 cycles.
REQ-020 SHALL pop on a rising edge where valid_o=1 and ready_i=1; data_o and valid_o SHALL be held stable while valid_o=1 and ready_i=0.
REQ-021 SHALL, on a simultaneous push and pop with the buffer full, accept the push and leave fill_o unchanged.
REQ-022 SHALL, on a simultaneous push and pop with the buffer empty, leave fill_o at 0 (no bypass).
REQ-023 SHALL, on a push to a full buffer without a pop, drop the new word, set overflow_o, and increment ovf_cnt_o (saturating at 8'hFF).
REQ-024 SHALL let read and write pointers wrap modulo FifoDepth; fill_o SHALL never exceed FifoDepth.
REQ-025 SHALL, on clear_i=1, zero fill_o, deassert valid_o, clear overflow_o and ovf_cnt_o, and go to IDLE at the next rising edge; clear_i takes priority over push and pop.

Reset
REQ-026 SHALL, while rst_ni=0, set the FSM to IDLE, pointers and fill_o to 0, valid_o=0, overflow_o=0, ovf_cnt_o=0, and data_o, rise_q and fall_q to Init.
REQ-027 SHALL, when reset is asserted mid-capture, discard any partial word; the first push after release occurs no earlier than 2 rising edges after en_i is seen high.

Configuration
REQ-028 SHALL, with HYPERBUS_DDR_IN_OVF_CNT_EN defined, implement the ovf_cnt_o counter as described above.
REQ-029 SHALL, without HYPERBUS_DDR_IN_OVF_CNT_EN, tie ovf_cnt_o to 8'h00 and implement no counter flops; overflow_o behaviour is unchanged.

Structure
REQ-030 SHALL place the FSM state enum and the word width constant (16) in package hyperbus_pkg.
REQ-031 SHALL implement the buffer as sub-module hyperbus_ddr_in_fifo, carrying the push/pop/full/empty/fill logic; the DDR capture and FSM stay in the top module.

Verification
REQ-032 SHALL cover basic capture: en_i=1, dq_i sequence A1,B2,C3,D4 on rise,fall,rise,fall -> words 16'hA1B2 then 16'hC3D4, first valid_o 2 cycles after the A1 rising edge.
REQ-033 SHALL cover backpressure: ready_i=0 with 4 words pushed at FifoDepth=4 -> fill_o=4, data_o stable; a 5th push -> overflow_o=1, ovf_cnt_o=1, the head word is still the first word.
REQ-034 SHALL cover a full buffer with simultaneous push and pop: fill_o stays 4, the popped word is the oldest, no overflow.
REQ-035 SHALL cover clear mid-stream: clear_i pulsed with fill_o=3 and overflow_o=1 -> next cycle fill_o=0, valid_o=0, overflow_o=0, FSM in IDLE.
REQ-036 SHALL cover async reset mid-capture: rst_ni low between edges -> outputs at reset values immediately; after release with en_i=1, no word is pushed before 2 rising edges.
REQ-037 SHALL cover counter saturation: 300 dropped words -> ovf_cnt_o=8'hFF with the macro defined, 8'h00 without it.
